// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free tags with branch checkpoints.
// Optional error tracking is built only when FREELIST_ERR_EN is defined.
module free_list #(
  parameter int unsigned NUM_PREGS = 128,
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned NUM_CKPT  = 4,
  localparam int unsigned TAG_W    = $clog2(NUM_PREGS),
  localparam int unsigned CKPT_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_req,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_pd,
  input  logic              free_valid,
  input  logic [TAG_W-1:0]  free_pd,
  input  logic              ckpt_save,
  input  logic [CKPT_W-1:0] ckpt_id,
  input  logic              restore,
  input  logic [CKPT_W-1:0] restore_id,
  output logic [TAG_W:0]    count,
  output logic              err
);

  localparam int unsigned  FREE_MAX = NUM_PREGS - NUM_AREGS;
  localparam logic [TAG_W:0] CNT_MAX = (TAG_W+1)'(FREE_MAX);

  logic [TAG_W-1:0] list_q [NUM_PREGS];
  logic [TAG_W-1:0] slot_q [NUM_CKPT];
  logic [TAG_W-1:0] r_ptr_q, r_ptr_d;
  logic [TAG_W-1:0] w_ptr_q, w_ptr_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             alloc_fire;
  logic             free_eff;
  logic             save_en;

  always_comb begin
    alloc_ready = (count_q != '0) && !restore;
    alloc_fire  = alloc_req && alloc_ready;
    // A free that would push the list past capacity is discarded.
    free_eff    = free_valid && (free_pd != '0) && (count_q != CNT_MAX);
    save_en     = ckpt_save && !restore;
    w_ptr_d     = w_ptr_q + {{(TAG_W-1){1'b0}}, free_eff};
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    if (restore) begin
      r_ptr_d = slot_q[restore_id];
      count_d = {1'b0, w_ptr_d - r_ptr_d};
    end else begin
      r_ptr_d = r_ptr_q + {{(TAG_W-1){1'b0}}, alloc_fire};
      count_d = count_q - {{TAG_W{1'b0}}, alloc_fire} + {{TAG_W{1'b0}}, free_eff};
    end
  end

  assign alloc_pd = list_q[r_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++) begin
        list_q[i] <= (i < FREE_MAX) ? TAG_W'(i + NUM_AREGS) : '0;
      end
    end else if (free_eff) begin
      list_q[w_ptr_q] <= free_pd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr_q <= '0;
      w_ptr_q <= TAG_W'(FREE_MAX);
      count_q <= CNT_MAX;
      for (int unsigned i = 0; i < NUM_CKPT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      r_ptr_q <= r_ptr_d;
      w_ptr_q <= w_ptr_d;
      count_q <= count_d;
      // Checkpoint captures the pointer after this cycle's allocation.
      if (save_en) begin
        slot_q[ckpt_id] <= r_ptr_d;
      end
    end
  end

`ifdef FREELIST_ERR_EN
  logic [NUM_CKPT-1:0] slot_vld_q;
  logic                err_q;
  logic                free_ovf;

  assign free_ovf = free_valid && (free_pd != '0) && (count_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_vld_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (save_en) begin
        slot_vld_q[ckpt_id] <= 1'b1;
      end
      if (free_ovf || (restore && !slot_vld_q[restore_id])) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: stimulus pushes expected outputs into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req;
  logic       alloc_ready;
  logic [6:0] alloc_pd;
  logic       free_valid;
  logic [6:0] free_pd;
  logic       ckpt_save;
  logic [1:0] ckpt_id;
  logic       restore;
  logic [1:0] restore_id;
  logic [7:0] count;
  logic       err;

`ifdef FREELIST_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  localparam logic [3:0] M_RDY = 4'b0001;
  localparam logic [3:0] M_PD  = 4'b0010;
  localparam logic [3:0] M_CNT = 4'b0100;
  localparam logic [3:0] M_ERR = 4'b1000;
  localparam logic [3:0] M_ALL = 4'b1111;

  typedef struct {
    string      name;
    logic [3:0] mask;
    logic       rdy;
    logic [6:0] pd;
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  exp_t        sb[$];
  logic [6:0]  model[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  free_list #(.NUM_PREGS(128), .NUM_AREGS(32), .NUM_CKPT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .alloc_req  (alloc_req),
    .alloc_ready(alloc_ready),
    .alloc_pd   (alloc_pd),
    .free_valid (free_valid),
    .free_pd    (free_pd),
    .ckpt_save  (ckpt_save),
    .ckpt_id    (ckpt_id),
    .restore    (restore),
    .restore_id (restore_id),
    .count      (count),
    .err        (err)
  );

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.mask[0]) begin
        n_tests++;
        if (alloc_ready !== e.rdy) begin
          n_fail++;
          $display("FAIL %s alloc_ready got %0b want %0b", e.name, alloc_ready, e.rdy);
        end
      end
      if (e.mask[1]) begin
        n_tests++;
        if (alloc_pd !== e.pd) begin
          n_fail++;
          $display("FAIL %s alloc_pd got %0d want %0d", e.name, alloc_pd, e.pd);
        end
      end
      if (e.mask[2]) begin
        n_tests++;
        if (count !== e.cnt) begin
          n_fail++;
          $display("FAIL %s count got %0d want %0d", e.name, count, e.cnt);
        end
      end
      if (e.mask[3]) begin
        n_tests++;
        if (err !== e.err) begin
          n_fail++;
          $display("FAIL %s err got %0b want %0b", e.name, err, e.err);
        end
      end
    end
  end

  task automatic drive(input logic areq, input logic fv, input logic [6:0] fpd,
                       input logic sv, input logic [1:0] sid,
                       input logic rs, input logic [1:0] rid);
    alloc_req  = areq;
    free_valid = fv;
    free_pd    = fpd;
    ckpt_save  = sv;
    ckpt_id    = sid;
    restore    = rs;
    restore_id = rid;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic chk(input string n, input logic [3:0] m, input logic r,
                     input logic [6:0] p, input logic [7:0] c, input logic e);
    exp_t x;
    x.name = n; x.mask = m; x.rdy = r; x.pd = p; x.cnt = c; x.err = e;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 7'd9, 1'b1, 2'd1, 1'b1, 2'd1);
    tick();
    reset = 1'b0;
    idle();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [6:0] t;
    reset = 1'b1;
    idle();
    tick();
    do_reset();

    // Reset state
    idle(); chk("reset", M_ALL, 1'b1, 7'd32, 8'd96, 1'b0); tick();

    // Three back-to-back allocations
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      chk("alloc3", M_RDY | M_PD | M_CNT, 1'b1, 7'(32 + i), 8'(96 - i), 1'b0);
      tick();
    end
    idle(); chk("alloc3_end", M_PD | M_CNT, 1'b1, 7'd35, 8'd93, 1'b0); tick();

    // Drain everything, then free into the empty list (no bypass)
    do_reset();
    for (int i = 0; i < 96; i++) begin
      drive(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      chk("drain", M_PD | M_CNT, 1'b1, 7'(32 + i), 8'(96 - i), 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 7'd40, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("empty", M_RDY | M_CNT, 1'b0, 7'd0, 8'd0, 1'b0); tick();
    idle(); chk("refill", M_RDY | M_PD | M_CNT, 1'b1, 7'd40, 8'd1, 1'b0); tick();

    // Simultaneous alloc and free of tag 5 at count 95
    do_reset();
    drive(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("af_pre", M_PD | M_CNT, 1'b1, 7'd32, 8'd96, 1'b0); tick();
    drive(1'b1, 1'b1, 7'd5, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("af_same", M_PD | M_CNT, 1'b1, 7'd33, 8'd95, 1'b0); tick();
    idle(); chk("af_after", M_PD | M_CNT, 1'b1, 7'd34, 8'd95, 1'b0); tick();
    for (int i = 0; i < 94; i++) begin
      drive(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      chk("af_walk", M_PD, 1'b1, 7'(34 + i), 8'd0, 1'b0);
      tick();
    end
    idle(); chk("af_tag5", M_RDY | M_PD | M_CNT, 1'b1, 7'd5, 8'd1, 1'b0); tick();

    // Checkpoint save / restore
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      chk("ck_a2", M_PD, 1'b1, 7'(32 + i), 8'd0, 1'b0); tick();
    end
    drive(1'b0, 1'b0, 7'd0, 1'b1, 2'd1, 1'b0, 2'd0);
    chk("ck_save", M_PD | M_CNT, 1'b1, 7'd34, 8'd94, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      chk("ck_a3", M_PD | M_CNT, 1'b1, 7'(34 + i), 8'(94 - i), 1'b0); tick();
    end
    drive(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b1, 2'd1);
    chk("rst_cyc", M_RDY | M_CNT, 1'b0, 7'd0, 8'd91, 1'b0); tick();
    idle(); chk("rst_after", M_RDY | M_PD | M_CNT, 1'b1, 7'd34, 8'd94, 1'b0); tick();

    // Save in an allocating cycle captures the post-alloc pointer
    drive(1'b1, 1'b0, 7'd0, 1'b1, 2'd2, 1'b0, 2'd0);
    chk("save_af", M_PD | M_CNT, 1'b1, 7'd34, 8'd94, 1'b0); tick();
    drive(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("save_af2", M_PD | M_CNT, 1'b1, 7'd35, 8'd93, 1'b0); tick();
    drive(1'b0, 1'b0, 7'd0, 1'b0, 2'd0, 1'b1, 2'd2);
    chk("rst2_cyc", M_RDY | M_CNT, 1'b0, 7'd0, 8'd92, 1'b0); tick();
    idle(); chk("rst2_after", M_PD | M_CNT, 1'b1, 7'd35, 8'd93, 1'b0); tick();

    // Restore together with a free of tag 70
    drive(1'b0, 1'b1, 7'd70, 1'b0, 2'd0, 1'b1, 2'd1);
    chk("rf_cyc", M_RDY | M_CNT, 1'b0, 7'd0, 8'd93, 1'b0); tick();
    idle(); chk("rf_after", M_PD | M_CNT, 1'b1, 7'd34, 8'd95, 1'b0); tick();

    // Restore beats a same-cycle save
    drive(1'b0, 1'b0, 7'd0, 1'b1, 2'd2, 1'b1, 2'd1);
    chk("rs_cyc", M_RDY, 1'b0, 7'd0, 8'd0, 1'b0); tick();
    drive(1'b0, 1'b0, 7'd0, 1'b0, 2'd0, 1'b1, 2'd2);
    chk("rs_cyc2", M_RDY | M_CNT, 1'b0, 7'd0, 8'd95, 1'b0); tick();
    idle(); chk("rs_drop", M_ALL, 1'b1, 7'd35, 8'd94, 1'b0); tick();

    // Overflowing free, p0 free, sticky err
    do_reset();
    drive(1'b0, 1'b1, 7'd100, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("ovf_cyc", M_CNT, 1'b1, 7'd0, 8'd96, 1'b0); tick();
    idle(); chk("ovf", M_ALL, 1'b1, 7'd32, 8'd96, ERR_ON); tick();
    drive(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0); tick();
    drive(1'b0, 1'b1, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0); tick();
    idle(); chk("p0_ignored", M_ALL, 1'b1, 7'd33, 8'd95, ERR_ON); tick();
    do_reset();
    idle(); chk("err_clr", M_ERR, 1'b1, 7'd0, 8'd0, 1'b0); tick();
    drive(1'b0, 1'b0, 7'd0, 1'b0, 2'd0, 1'b1, 2'd3); tick();
    idle(); chk("unsaved", M_ALL, 1'b1, 7'd32, 8'd96, ERR_ON); tick();

    // Wrap: sustained alloc+free, FIFO order against a queue model
    do_reset();
    model.delete();
    for (int i = 0; i < 96; i++) model.push_back(7'(32 + i));
    t = model.pop_front();
    drive(1'b1, 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("wrap_pre", M_PD | M_CNT, 1'b1, t, 8'd96, 1'b0); tick();
    for (int i = 0; i < 300; i++) begin
      logic [6:0] f;
      f = 7'((i * 7) % 126 + 1);
      t = model.pop_front();
      model.push_back(f);
      drive(1'b1, 1'b1, f, 1'b0, 2'd0, 1'b0, 2'd0);
      chk("wrap", M_PD | M_CNT, 1'b1, t, 8'd95, 1'b0);
      tick();
    end
    idle(); chk("wrap_end", M_ALL, 1'b1, model[0], 8'd95, 1'b0); tick();

    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain scoreboard left %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
